// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - memory-mapped PORT/PIN/UART-TX bridge for the MIPS data bus
//
// Purpose: decodes a 3-word I/O window beside data memory. PORT drives the
// registered PortOut, PIN reads back a synchronised PortIn, TXDATA queues
// bytes into a small FIFO that an 8N1 transmitter drains, STATUS reports
// FIFO/transmitter state and a sticky overflow flag.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   Address, WriteData    - processor data-bus address and store data
//   MemWrite, MemRead     - store / load strobes
//   PortIn                - asynchronous 8-bit input
//   ReadData, io_sel      - combinational load data and window-hit flag
//   PortOut               - registered output port
//   tx, tx_busy           - UART line (idle high) and frame-in-progress flag

module io_port_bridge #(
  parameter logic [31:0] IO_BASE      = 32'h1001_0040,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        io_sel,
  output logic [31:0] PortOut,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [7:0]    pin_s1, pin_s2;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Address decode: full 32-bit compares, so aliases never hit.
  logic hit_port, hit_tx, hit_pin;
  assign hit_port = (Address == IO_BASE);
  assign hit_tx   = (Address == IO_BASE + 32'd4);
  assign hit_pin  = (Address == IO_BASE + 32'd8);
  assign io_sel   = hit_port | hit_tx | hit_pin;

  logic full, empty, baud_last, pop, push_req, push_ok, ovf_set, status_rd;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  // The transmitter pops when idle, or at the last stop-bit cycle so the
  // next start bit follows with no idle gap.
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_last));
  assign push_req  = MemWrite && hit_tx;
  // A pop in the same edge frees a slot, so a push into a full FIFO still fits.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign status_rd = MemRead && hit_tx;

  logic [31:0] count_ext;
  assign count_ext = 32'(count);

  // PortOut register and PortIn synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut <= '0;
      pin_s1  <= '0;
      pin_s2  <= '0;
    end else begin
      if (MemWrite && hit_port) PortOut <= WriteData;
      pin_s1 <= PortIn;
      pin_s2 <= pin_s1;
    end
  end

  // TX FIFO and sticky overflow flag; set wins over a same-edge STATUS read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      if (ovf_set)        ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (baud_last) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    case (state)
      IDLE:  tx_busy = 1'b0;
      START: tx      = 1'b0;
      DATA:  tx      = shift[0];
      STOP:  tx      = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

  // Transmitter datapath: baud counter, bit index, shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state == IDLE || baud_last) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (pop) shift <= fifo_mem[rd_ptr];
      if (state == START && baud_last) bit_idx <= '0;
      if (state == DATA && baud_last) begin
        bit_idx <= bit_idx + 3'd1;
        shift   <= {1'b0, shift[7:1]};
      end
    end
  end

  // Load data is driven whenever the window is hit, independent of MemRead.
  always_comb begin
    ReadData = '0;
    if (hit_port)     ReadData = PortOut;
    else if (hit_tx)  ReadData = {25'b0, ovf, count_ext[2:0], tx_busy, empty, full};
    else if (hit_pin) ReadData = {24'b0, pin_s2};
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// tb/tb_io_port_bridge.sv - directed self-checking bench for io_port_bridge

module tb_io_port_bridge;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        io_sel;
  logic [31:0] PortOut;
  logic        tx;
  logic        tx_busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  io_port_bridge #(
    .IO_BASE(BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .PortIn(PortIn),
    .ReadData(ReadData),
    .io_sel(io_sel),
    .PortOut(PortOut),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected line level at bit slot pos (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Line level for the overflow stream: bytes 01..05 back-to-back, cycle c from E1.
  function automatic logic stream_bit(input int c);
    logic [7:0] b;
    b = 8'(c / 40 + 1);
    return frame_bit(b, (c % 40) / 4);
  endfunction

  logic [31:0] ovf_status [6];
  int          low_cnt;
  logic [7:0]  a5;

  initial begin
    ovf_status[0] = 32'h08; ovf_status[1] = 32'h0C; ovf_status[2] = 32'h14;
    ovf_status[3] = 32'h1C; ovf_status[4] = 32'h25; ovf_status[5] = 32'h65;
    a5 = 8'hA5;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    Address = BASE + 32'd4;
    #1;
    check("rst_portout", PortOut, 32'h0);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(tx_busy), 32'h0);
    check("rst_status", ReadData, 32'h2);
    reset = 1'b0;

    // PORT store and readback, plus an out-of-window load.
    Address = BASE; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
    @(negedge clk); #1;
    MemWrite = 1'b0;
    check("port_out", PortOut, 32'hDEAD_BEEF);
    #1;
    check("port_rd", ReadData, 32'hDEAD_BEEF);
    check("port_sel", 32'(io_sel), 32'h1);
    Address = BASE + 32'd12; #1;
    check("miss_rd", ReadData, 32'h0);
    check("miss_sel", 32'(io_sel), 32'h0);

    // Single frame of 0xA5.
    Address = BASE + 32'd4; WriteData = 32'h0000_00A5; MemWrite = 1'b1;
    @(negedge clk); #1;
    MemWrite = 1'b0;
    check("a5_pre_tx", 32'(tx), 32'h1);
    check("a5_pre_busy", 32'(tx_busy), 32'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      check($sformatf("a5_tx[%0d]", k), 32'(tx), 32'(frame_bit(a5, k / 4)));
      check($sformatf("a5_busy[%0d]", k), 32'(tx_busy), 32'h1);
    end
    @(negedge clk); #1;
    check("a5_post_tx", 32'(tx), 32'h1);
    check("a5_post_busy", 32'(tx_busy), 32'h0);

    // Overflow: 01..06 on consecutive edges; STATUS shares the TXDATA address.
    for (int i = 1; i <= 6; i++) begin
      Address = BASE + 32'd4; WriteData = 32'(i); MemWrite = 1'b1;
      @(negedge clk); #1;
      check($sformatf("ovf_status[%0d]", i), ReadData, ovf_status[i-1]);
      if (i >= 2) check($sformatf("ovf_tx[%0d]", i - 2), 32'(tx), 32'(stream_bit(i - 2)));
    end
    MemWrite = 1'b0; MemRead = 1'b1;
    @(negedge clk); #1;
    MemRead = 1'b0;
    check("ovf_clear", ReadData, 32'h25);
    check("ovf_tx[5]", 32'(tx), 32'(stream_bit(5)));
    for (int c = 6; c < 200; c++) begin
      @(negedge clk); #1;
      check($sformatf("ovf_tx[%0d]", c), 32'(tx), 32'(stream_bit(c)));
    end
    @(negedge clk); #1;
    check("ovf_done_busy", 32'(tx_busy), 32'h0);
    check("ovf_done_status", ReadData, 32'h2);

    // PIN synchroniser latency.
    PortIn = 8'h3C; Address = BASE + 32'd8; #1;
    check("pin_e0", ReadData, 32'h0);
    check("pin_sel", 32'(io_sel), 32'h1);
    @(negedge clk); #1;
    check("pin_e1", ReadData, 32'h0);
    @(negedge clk); #1;
    check("pin_e2", ReadData, 32'h3C);

    // Mid-frame reset with two bytes still queued.
    for (int j = 0; j < 3; j++) begin
      Address = BASE + 32'd4; WriteData = 32'h11 * (j + 1); MemWrite = 1'b1;
      @(negedge clk); #1;
    end
    MemWrite = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    check("mid_busy", 32'(tx_busy), 32'h1);
    check("mid_bit3", 32'(tx), 32'h0);
    check("mid_status", ReadData, 32'h14);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("mrst_tx", 32'(tx), 32'h1);
    check("mrst_busy", 32'(tx_busy), 32'h0);
    check("mrst_status", ReadData, 32'h2);
    low_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!tx || tx_busy) low_cnt++;
    end
    check("mrst_no_frame", 32'(low_cnt), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Memory-mapped I/O block on the MIPS single-cycle processor's data bus, beside the data memory. It decodes word accesses in a small I/O window and drives the processor's `PortOut` register. It also synchronises `PortIn` for readback and serialises bytes written by software onto an 8N1 UART line through a small transmit FIFO. The processor muxes `ReadData` from this block in place of RAM data whenever `io_sel` is high.

## Interface
Parameters:
- `IO_BASE`, default 32'h1001_0040: word-aligned base of the 3-word I/O window.
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; legal minimum is 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of two.

Ports:
- `clk`  in  1: single clock; every register updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `Address`  in  32: ALU result from the processor's data bus.
- `WriteData`  in  32: store data (ReadData2).
- `MemWrite`  in  1: store strobe.
- `MemRead`  in  1: load strobe.
- `PortIn`  in  8: asynchronous external input.
- `ReadData`  out  32: combinational load data.
- `io_sel`  out  1: combinational; high when `Address` hits the window.
- `PortOut`  out  32: registered output port.
- `tx`  out  1: UART serial output; idle high.
- `tx_busy`  out  1: high while a frame is on the line.

## Operation
- Decode uses a full 32-bit compare against three addresses:
  - `IO_BASE+0` is PORT (read/write).
  - `IO_BASE+4` is TXDATA on write and STATUS on read.
  - `IO_BASE+8` is PIN (read-only).
- Any other address gives `io_sel=0` and `ReadData=0`. Writes to PIN are ignored.
- PORT store: `PortOut` takes `WriteData` at the edge. A PORT read returns `PortOut`.
- TXDATA store pushes `WriteData[7:0]` into the FIFO.
  - If the FIFO is full and no pop occurs at the same edge, the byte is dropped and the sticky `ovf` flag is set.
  - A push and a pop at the same edge while full are both accepted; the count is unchanged.
- STATUS read returns {25'b0, `ovf`, count[2:0], `tx_busy`, empty, full}, i.e. bit0 full, bit1 empty, bit2 busy, bits[5:3] count, bit6 `ovf`.
  - `ovf` clears at the edge of a STATUS read (`MemRead` high at that address).
  - If an overflow and a STATUS read happen at the same edge, `ovf` ends set.
- PIN read returns {24'b0, `pin_s2`}, where `pin_s2` comes from a two-flop synchroniser on `PortIn`.
- `ReadData` is driven regardless of `MemRead`. Only the `ovf` clear is gated by `MemRead`.
- TX FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, clear the baud counter and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=shift[0], LSB first; each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `tx_busy`=1 in START, DATA and STOP.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. The count is log2(`FIFO_DEPTH`)+1 bits. STATUS count is truncated or zero-extended to 3 bits.

## Timing
- Reset values: `PortOut`=0, `tx`=1, `tx_busy`=0, FIFO empty (count 0, pointers 0), `ovf`=0, synchroniser flops 0, FSM in IDLE, baud counter 0.
- Reset during a frame aborts it: `tx` returns high on the next edge and FIFO contents are discarded.
- PORT store: `PortOut` updates at the same edge (E0) the store is sampled.
- TXDATA store into an empty FIFO with the FSM idle:
  - push at E0;
  - pop and START entry at E1, so `tx` is low after E1;
  - frame length is exactly 10×`CLKS_PER_BIT` cycles.
- PortIn to PIN readback latency is 2 edges.
- `ReadData` and `io_sel` have zero latency; they are combinational from `Address` and registered state.
- Back-to-back frames have no idle cycles between the stop bit and the next start bit.

## Test plan
- Reset: after `reset` is held for 2 edges, check `PortOut`=0, `tx`=1, `tx_busy`=0, STATUS=32'h0000_0002.
- PORT: store 32'hDEAD_BEEF to `IO_BASE` → `PortOut`=32'hDEAD_BEEF one edge later; load from `IO_BASE` returns the same value; a load from `IO_BASE+12` returns 0 with `io_sel`=0.
- TX frame (`CLKS_PER_BIT`=4): store 32'h0000_00A5 to `IO_BASE+4` → `tx` low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; `tx_busy` high for 40 cycles.
- FIFO overflow: stores 8'h01..8'h06 on consecutive cycles (`CLKS_PER_BIT`=4, depth 4) → byte 01 popped at E1; 02–05 fill the FIFO (STATUS full=1, count=4); 06 dropped with `ovf`=1; the line carries 01,02,03,04,05 with no gaps; a STATUS read clears `ovf` at its edge.
- PIN: drive `PortIn`=8'h3C → a PIN load returns 32'h0000_003C from the second edge onward, and 0 before that.
- Mid-frame reset: assert `reset` during bit 3 of a frame with 2 bytes queued → `tx`=1, empty=1, `tx_busy`=0 after the edge; no further frames are sent.
